// File: rtl/color_fsm_pkg.sv
// color_fsm_pkg: shared types and codes for the color FSM driver
package color_fsm_pkg;
    typedef enum logic [1:0] {BLUE = 2'd0, RED = 2'd1, HSV_IDLE = 2'd2} color_t;
    typedef enum logic [1:0] {ST_OK = 2'd0, ST_TIMEOUT = 2'd1, ST_ILLEGAL = 2'd2} status_t;
    typedef enum logic [1:0] {IDLE, STEP, CHECK, DONE} state_t;
    localparam logic [1:0] CMD_HOLD = 2'd3;
    localparam logic [1:0] TGT_ILLEGAL = 2'd3;
    localparam logic [1:0] CODE_BLUE = 2'd1;
    localparam logic [1:0] CODE_RED = 2'd2;
    localparam logic [1:0] CODE_HSV = 2'd2;
endpackage

// File: rtl/color_fsm_driver_planner.sv
// color_hop_planner: picks the next hop toward a target; every route passes through Red
module color_hop_planner
    import color_fsm_pkg::*;
(
    input  color_t     shadow,
    input  color_t     target,
    output logic [1:0] hop_cmd,
    output color_t     hop_dest,
    output logic [1:0] hop_code,
    output logic       last_hop
);
    assign hop_dest = (shadow == RED) ? target : RED;
    assign hop_cmd  = (shadow == HSV_IDLE) ? 2'd0 : (shadow == BLUE || target == BLUE) ? 2'd1 : 2'd2;
    assign hop_code = (hop_dest == BLUE) ? CODE_BLUE : (hop_dest == RED) ? CODE_RED : CODE_HSV;
    assign last_hop = hop_dest == target;
endmodule

// File: rtl/color_fsm_driver.sv
// color_fsm_driver: steers the color FSM to a requested state and confirms each hop
module color_fsm_driver
    import color_fsm_pkg::*;
#(
    parameter int TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_target,
    output logic [1:0] cmd_in,
    input  logic [1:0] obs_out,
    output logic       done_valid,
    output logic [1:0] done_status,
    output logic       busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state, state_n;
    color_t          shadow, shadow_n, tgt, tgt_n, hop_dest, dest_q;
    status_t         status, status_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      hop_cmd, hop_code, code_q, cmd_q;
    logic            last_hop, last_q;

    // planned from next-cycle shadow/target so the hop command can be registered on entry to STEP
    color_hop_planner planner (
        .shadow   (shadow_n),
        .target   (tgt_n),
        .hop_cmd  (hop_cmd),
        .hop_dest (hop_dest),
        .hop_code (hop_code),
        .last_hop (last_hop)
    );

    // next-state, shadow tracking and mismatch counting
    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        tgt_n    = tgt;
        cnt_n    = cnt;
        status_n = status;
        unique case (state)
            IDLE: if (req_valid) begin
                if (req_target == TGT_ILLEGAL) begin
                    state_n  = DONE;
                    status_n = ST_ILLEGAL;
                end else begin
                    tgt_n    = color_t'(req_target);
                    state_n  = (color_t'(req_target) == shadow) ? DONE : STEP;
                    status_n = ST_OK;
                end
            end
            STEP: begin
                state_n = CHECK;
                cnt_n   = '0;
            end
            CHECK: if (obs_out == code_q) begin
                shadow_n = dest_q;
                state_n  = last_q ? DONE : STEP;
                status_n = ST_OK;
            end else begin
                cnt_n = (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
                if (cnt_n == CW'(TIMEOUT)) begin
                    state_n  = DONE;
                    status_n = ST_TIMEOUT;
                    shadow_n = (obs_out == CODE_BLUE) ? BLUE : (obs_out == CODE_RED) ? RED : shadow;
                end
            end
            DONE: state_n = IDLE;
        endcase
    end

    // state, shadow, latched hop plan and registered command
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shadow <= RED;
            tgt    <= RED;
            cnt    <= '0;
            status <= ST_OK;
            cmd_q  <= CMD_HOLD;
            dest_q <= RED;
            code_q <= CODE_RED;
            last_q <= 1'b0;
        end else begin
            state  <= state_n;
            shadow <= shadow_n;
            tgt    <= tgt_n;
            cnt    <= cnt_n;
            cmd_q  <= (state_n == STEP) ? hop_cmd : CMD_HOLD;
            if (state_n == DONE) status <= status_n;
            if (state_n == STEP) begin
                dest_q <= hop_dest;
                code_q <= hop_code;
                last_q <= last_hop;
            end
        end
    end

    assign req_ready   = (state == IDLE) && !rst;
    assign busy        = state != IDLE;
    assign cmd_in      = cmd_q;
    assign done_valid  = state == DONE;
    assign done_status = status;
endmodule

// File: tb/tb_color_fsm_driver.sv
// tb_color_fsm_driver: scoreboard bench driving the driver against a model of the color FSM
module tb_color_fsm_driver;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_target = 2'd0;
    logic       req_ready, done_valid, busy;
    logic [1:0] cmd_in, obs_out, done_status;
    logic       forced = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fsm = 1;
    int ms = 1;

    typedef struct {
        int status;
        int cyc;
        int n;
        int c0;
        int c1;
        bit chk_out;
        int out;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   log_q[$];

    color_fsm_driver #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_target  (req_target),
        .cmd_in      (cmd_in),
        .obs_out     (obs_out),
        .done_valid  (done_valid),
        .done_status (done_status),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // color FSM: positions 0 Blue, 1 Red, 2 HSV idle; unknown commands hold
    function automatic int fsm_next(int s, int c);
        if (s == 0 && c == 1) return 1;
        if (s == 1 && c == 1) return 0;
        if (s == 1 && c == 2) return 2;
        if (s == 2 && c == 0) return 1;
        return s;
    endfunction

    always @(posedge clk) fsm <= rst ? 1 : fsm_next(fsm, int'(cmd_in));

    always_comb obs_out = forced ? 2'd2 : (fsm == 0 ? 2'd1 : 2'd2);

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    // monitor: collect issued commands, compare each completion with the scoreboard head
    always @(negedge clk) begin
        if (rst) log_q.delete();
        else begin
            if (cmd_in != 2'd3) log_q.push_back(int'(cmd_in));
            if (done_valid) begin
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    me = q.pop_front();
                    chk("status", int'(done_status), me.status);
                    chk("done_cycle", cyc, me.cyc);
                    chk("cmd_count", log_q.size(), me.n);
                    if (me.n > 0) chk("cmd0", log_q.size() > 0 ? log_q[0] : -1, me.c0);
                    if (me.n > 1) chk("cmd1", log_q.size() > 1 ? log_q[1] : -1, me.c1);
                    if (me.chk_out) chk("fsm_out", int'(obs_out), me.out);
                end
                log_q.delete();
            end
        end
    end

    // reference: walk the Blue-Red-HSV line one position at a time
    task automatic req(int tg);
        exp_t e;
        int   p, d, hops, lat, st, cv, n;
        e.n = 0;
        e.c0 = -1;
        e.c1 = -1;
        p = ms;
        st = 0;
        if (tg == 3) lat = 1;
        else begin
            hops = tg > ms ? tg - ms : ms - tg;
            lat = hops == 0 ? 1 : 1 + 2 * hops;
            for (int i = 0; i < hops; i++) begin
                d = tg > p ? p + 1 : p - 1;
                cv = (d == 2) ? 2 : (p == 2) ? 0 : 1;
                if (i == 0) e.c0 = cv; else e.c1 = cv;
                e.n++;
                if (forced && d == 0) begin
                    st = 2'd1;
                    lat = 2 + 2 * i + TO;
                    p = 1;
                    break;
                end
                p = d;
            end
        end
        if (tg == 3) st = 2;
        ms = p;
        e.status = st;
        e.chk_out = !forced;
        e.out = ms == 0 ? 1 : 2;
        @(negedge clk);
        req_valid = 1'b1;
        req_target = 2'(tg);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        e.cyc = cyc + lat;
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_target = 2'($urandom_range(0, 3));
        n = 0;
        while (q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            chk("done_timeout", 0, 1);
            q.delete();
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ms = 1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_cmd_in", int'(cmd_in), 3);
        chk("rst_done_valid", int'(done_valid), 0);
        chk("rst_done_status", int'(done_status), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        ms = 1;
        @(negedge clk);
        chk("idle_req_ready", int'(req_ready), 1);
        req(0);
        req(2);
        pulse_rst();
        req(1);
        req(3);
        chk("status_hold", int'(done_status), 2);
        chk("hold_done_valid", int'(done_valid), 0);
        forced = 1'b1;
        req(0);
        forced = 1'b0;
        pulse_rst();
        req(0);
        @(negedge clk);
        req_valid = 1'b1;
        req_target = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_check_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ms = 1;
        chk("abort_cmd_in", int'(cmd_in), 3);
        chk("abort_done_valid", int'(done_valid), 0);
        @(negedge clk);
        chk("abort_req_ready", int'(req_ready), 1);
        chk("abort_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                forced = 1'b1;
                req(int'($urandom_range(0, 3)));
                forced = 1'b0;
                pulse_rst();
            end else req(int'($urandom_range(0, 3)));
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/color_fsm_driver.md
# color_fsm_driver

Initiator for the two-bit color state machine interface: accepts a requested color state over a valid/ready handshake and produces the `in` command sequence that steers the color FSM there. It watches the FSM's two-bit `out` code to confirm each hop. It keeps a shadow copy of the FSM state, because code 2'h2 is shared by Red and HSV idle. It sits beside the color FSM on the same clock and reset, and wires `cmd_in` to the FSM's `in` and the FSM's `out` to `obs_out`.

## Interface
- `TIMEOUT`, default 4: consecutive mismatching CHECK cycles tolerated before a hop is declared failed; minimum 1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  driver can accept a request; high only in IDLE.
- `req_target`  in  2  requested state: 0 Blue, 1 Red, 2 HSV idle, 3 illegal.
- `cmd_in`  out  2  registered command to the color FSM's `in`.
- `obs_out`  in  2  color FSM's `out` code: Blue→1, Red→2, HSV idle→2.
- `done_valid`  out  1  one-cycle completion pulse.
- `done_status`  out  2  valid with `done_valid`: 0 OK, 1 timeout, 2 illegal target.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Shadow state resets to Red, because the color FSM resets to Red on the same reset.
- Hold command is 2'h3; it keeps Blue, Red and HSV idle unchanged. `cmd_in` = 2'h3 in every cycle except STEP.
- Single-hop commands:
  - Blue→Red: 1
  - Red→Blue: 1
  - Red→HSV: 2
  - HSV→Red: 0
- Two-hop routes:
  - Blue→HSV: 1, then 2 (via Red)
  - HSV→Blue: 0, then 1 (via Red)
- FSM states: IDLE, STEP, CHECK, DONE.
  - IDLE: `req_ready`=1. On `req_valid`, latch the target.
    - Target 3 → DONE, status 2.
    - Target equal to shadow → DONE, status 0.
    - Otherwise → STEP.
  - STEP: drive the next hop command for exactly one cycle, then go to CHECK. Clear the mismatch counter.
  - CHECK:
    - `obs_out` equals the hop's expected code: shadow ← hop destination. Go to STEP if the final target is not yet reached, else DONE with status 0.
    - Otherwise: increment the counter. When it reaches `TIMEOUT`, go to DONE with status 1 and resync shadow from `obs_out`: 1→Blue, 2→Red, other codes leave shadow unchanged.
  - DONE: `done_valid`=1 for one cycle with status, then IDLE.
- `done_status` holds its last value while `done_valid`=0.
- Mismatch counter width is $clog2(TIMEOUT+1) and it saturates; no wrap.

## Timing
- Reset values: `req_ready`=0 during reset (IDLE afterwards gives 1), `cmd_in`=2'h3, `done_valid`=0, `done_status`=0, `busy`=0. Internal reset values: shadow Red, counter 0.
- Request accepted at edge t (`req_valid` & `req_ready`).
- Zero-hop or illegal request: DONE in cycle t+1.
- One hop (no mismatch):
  - STEP in t+1: `cmd_in` is valid and is sampled by the color FSM at the end of t+1.
  - CHECK in t+2: sees the new code.
  - DONE in t+3; `req_ready` again in t+4.
- Two hops: DONE in t+5.
- Timeout on a hop whose CHECK starts in cycle c: DONE in c+TIMEOUT. With default 4 on a single hop, DONE in t+6.
- Back-to-back requests: a request may be accepted in the cycle after DONE.
- `rst` mid-operation: the next cycle is IDLE with reset values. No `done_valid` is issued for an aborted request.

## Structure
- Package `color_fsm_pkg` holds:
  - target/state enum: BLUE=0, RED=1, HSV_IDLE=2
  - status enum: OK=0, TIMEOUT=1, ILLEGAL=2
  - command constants: CMD_HOLD=3
  - output code constants: CODE_BLUE=1, CODE_RED=2, CODE_HSV=2
- Sub-module `color_hop_planner`, purely combinational. Inputs: shadow, target. Outputs: hop command, hop destination, expected code, last-hop flag.

## Test plan
- After reset, request Blue against the real color FSM → `cmd_in`=1 in t+1, DONE t+3 status 0, FSM `out`=1.
- From Blue, request HSV idle → commands 1 then 2, DONE t+5 status 0, FSM in HSV idle (`out`=2).
- Request equal to current state (Red after reset) → no non-3 command, DONE t+1 status 0.
- `req_target`=3 → DONE t+1 status 2, `cmd_in` stays 3, shadow unchanged.
- `obs_out` forced to 2 while requesting Blue, `TIMEOUT`=4 → DONE t+6 status 1, shadow Red.
- `rst` asserted during CHECK of a two-hop request → no `done_valid`, `cmd_in`=3, `req_ready`=1 one cycle after reset deasserts.
